div_exec_ctrl: RTL and testbench

//  Sequencer for the integer divide unit: accepts one op from the divide queue, runs a

---
 rtl/div_exec_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_div_exec_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_exec_ctrl.sv
// Integer divide sequencer: radix-2 restoring divide with RISC-V DIV/DIVU/REM/REMU
// special cases, result held for CDB grant, killed by flush.
module div_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [1:0]        q_op,
  input  logic [DATA_W-1:0] q_rs1,
  input  logic [DATA_W-1:0] q_rs2,
  input  logic [TAG_W-1:0]  q_tag,
  input  logic              flush,
  output logic              div_ready,
  output logic              div_busy,
  output logic [DATA_W-1:0] div_result,
  output logic [TAG_W-1:0]  div_tag,
  input  logic              div_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_INT  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] divisor_r, quot_r, rem_r;
  logic [TAG_W-1:0]  tag_r;
  logic              rem_sel_r, quot_neg_r, rem_neg_r, special_r;

  logic              accept_s, is_signed_s, sign1_s, sign2_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [DATA_W-1:0] abs1_s, abs2_s, special_val_s;
  logic [DATA_W:0]   shift_s;
  logic              ge_s;
  logic [DATA_W-1:0] rem_step_s, quot_step_s;
  logic [DATA_W-1:0] quot_fix_s, rem_fix_s, fix_result_s;

  assign q_ready  = (state_r == IDLE) & ~flush & ~rst;
  assign accept_s = q_valid & q_ready;

  // Operand decode at accept: magnitudes, result signs and special-case results
  always_comb begin
    is_signed_s = ~q_op[0];
    sign1_s     = is_signed_s & q_rs1[DATA_W-1];
    sign2_s     = is_signed_s & q_rs2[DATA_W-1];
    abs1_s      = sign1_s ? negate(q_rs1) : q_rs1;
    abs2_s      = sign2_s ? negate(q_rs2) : q_rs2;
    div_zero_s  = (q_rs2 == ZERO);
    ovf_s       = is_signed_s & (q_rs1 == MIN_INT) & (q_rs2 == ALL_ONES);
    special_s   = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_val_s = q_op[1] ? q_rs1 : ALL_ONES;
    end else begin
      special_val_s = q_op[1] ? ZERO : MIN_INT;
    end
  end

  // One restoring step; the compare is DATA_W+1 bits so the shifted-out bit counts
  always_comb begin
    shift_s     = {rem_r, quot_r[DATA_W-1]};
    ge_s        = (shift_s >= {1'b0, divisor_r});
    if (ge_s) begin
      rem_step_s = shift_s[DATA_W-1:0] - divisor_r;
    end else begin
      rem_step_s = shift_s[DATA_W-1:0];
    end
    quot_step_s = {quot_r[DATA_W-2:0], ge_s};
  end

  // Sign correction and quotient/remainder select; special results ride in quot_r
  always_comb begin
    quot_fix_s = quot_neg_r ? negate(quot_r) : quot_r;
    rem_fix_s  = rem_neg_r ? negate(rem_r) : rem_r;
    if (special_r) begin
      fix_result_s = quot_r;
    end else begin
      fix_result_s = rem_sel_r ? rem_fix_s : quot_fix_s;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = special_s ? FIX : CALC;
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CNT_LAST) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
        FIX: state_s = DONE;
        DONE: begin
          if (div_done) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      divisor_r  <= ZERO;
      quot_r     <= ZERO;
      rem_r      <= ZERO;
      tag_r      <= {TAG_W{1'b0}};
      rem_sel_r  <= 1'b0;
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      special_r  <= 1'b0;
      div_ready  <= 1'b0;
      div_busy   <= 1'b0;
      div_result <= ZERO;
      div_tag    <= {TAG_W{1'b0}};
    end else begin
      state_r   <= state_s;
      div_ready <= (state_s == DONE);
      div_busy  <= (state_s == CALC) | (state_s == FIX);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            tag_r      <= q_tag;
            rem_sel_r  <= q_op[1];
            cnt_r      <= {CNT_W{1'b0}};
            rem_r      <= ZERO;
            divisor_r  <= abs2_s;
            special_r  <= special_s;
            quot_r     <= special_s ? special_val_s : abs1_s;
            quot_neg_r <= ~special_s & (sign1_s ^ sign2_s);
            rem_neg_r  <= ~special_s & sign1_s;
          end
        end
        CALC: begin
          rem_r  <= rem_step_s;
          quot_r <= quot_step_s;
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          div_result <= fix_result_s;
          div_tag    <= tag_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_exec_ctrl.sv
// Self-checking bench for div_exec_ctrl: scoreboard of expected result/tag/latency
// per op, plus hold, flush and reset scenarios.
module tb_div_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst, q_valid, flush, div_done;
  logic        q_ready, div_ready, div_busy;
  logic [1:0]  q_op;
  logic [31:0] q_rs1, q_rs2, div_result;
  logic [5:0]  q_tag, div_tag;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  div_exec_ctrl #(.DATA_W(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_op(q_op),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_tag(q_tag), .flush(flush),
    .div_ready(div_ready), .div_busy(div_busy), .div_result(div_result),
    .div_tag(div_tag), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic send_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [31:0] res, input int lat);
    exp_t e;
    @(negedge clk);
    q_valid = 1'b1; q_op = op; q_rs1 = a; q_rs2 = b; q_tag = tag;
    e.res = res; e.tag = tag; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 q_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc = i + 1;
      if (div_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic grant();
    @(negedge clk);
    div_done = 1'b1;
    @(posedge clk);
    #1 div_done = 1'b0;
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; q_valid = 1'b0; flush = 1'b0; div_done = 1'b0;
    q_op = 2'b00; q_rs1 = 32'd0; q_rs2 = 32'd0; q_tag = 6'd0;
    repeat (2) @(negedge clk);
    total_cnt++; if (div_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", div_ready); else pass_cnt++;
    total_cnt++; if (div_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", div_busy); else pass_cnt++;
    total_cnt++; if (div_result !== 32'd0) $display("FAIL reset_result got %h want 0", div_result); else pass_cnt++;
    total_cnt++; if (div_tag !== 6'd0) $display("FAIL reset_tag got %h want 0", div_tag); else pass_cnt++;
    total_cnt++; if (q_ready !== 1'b0) $display("FAIL reset_q_ready got %0b want 0", q_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (q_ready !== 1'b1) $display("FAIL idle_q_ready got %0b want 1", q_ready); else pass_cnt++;
  endtask

  task automatic test_basic_ops();
    vec_t vt[10];
    exp_t e;
    int cyc;
    bit ok;
    vt = '{'{2'b01, 32'd100,        32'd7,          32'd14,         33},
           '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
           '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
           '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1,          33},
           '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  33},
           '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33},
           '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
           '{2'b11, 32'd5,          32'd0,          32'd5,          1},
           '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
           '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}};
    for (int i = 0; i < 10; i++) begin
      send_op(vt[i].op, vt[i].a, vt[i].b, 6'(i + 5), vt[i].res, vt[i].lat);
      wait_ready(cyc, ok);
      e = sb.pop_front();
      total_cnt++; if (ok !== 1'b1) $display("FAIL op%0d_timeout got no div_ready want div_ready", i); else pass_cnt++;
      total_cnt++; if (cyc !== e.lat) $display("FAIL op%0d_latency got %0d want %0d", i, cyc, e.lat); else pass_cnt++;
      total_cnt++; if (div_result !== e.res) $display("FAIL op%0d_result got %h want %h", i, div_result, e.res); else pass_cnt++;
      total_cnt++; if (div_tag !== e.tag) $display("FAIL op%0d_tag got %h want %h", i, div_tag, e.tag); else pass_cnt++;
      total_cnt++; if ({div_busy, q_ready} !== 2'b00) $display("FAIL op%0d_done_flags got %b want 00", i, {div_busy, q_ready}); else pass_cnt++;
      grant();
      @(negedge clk);
      total_cnt++; if ({div_ready, q_ready} !== 2'b01) $display("FAIL op%0d_release got %b want 01", i, {div_ready, q_ready}); else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    exp_t e, e2;
    int cyc;
    bit ok;
    send_op(2'b01, 32'd50, 32'd5, 6'd9, 32'd10, 33);
    wait_ready(cyc, ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1 || div_result !== e.res) $display("FAIL hold_first got %h want %h", div_result, e.res); else pass_cnt++;
    @(negedge clk);
    q_valid = 1'b1; q_op = 2'b01; q_rs1 = 32'd81; q_rs2 = 32'd9; q_tag = 6'd10;
    e2.res = 32'd9; e2.tag = 6'd10; e2.lat = 33;
    sb.push_back(e2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({div_ready, div_busy, q_ready} !== 3'b100 || div_result !== e.res || div_tag !== e.tag)
        $display("FAIL hold_cycle%0d got rdy/busy/qr=%b res=%h tag=%h want 100 %h %h",
                 i, {div_ready, div_busy, q_ready}, div_result, div_tag, e.res, e.tag);
      else pass_cnt++;
    end
    grant();
    @(negedge clk);
    total_cnt++; if ({div_ready, div_busy, q_ready} !== 3'b001) $display("FAIL hold_no_accept_in_grant got %b want 001", {div_ready, div_busy, q_ready}); else pass_cnt++;
    @(posedge clk);
    #1 q_valid = 1'b0;
    wait_ready(cyc, ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1 || cyc !== e.lat) $display("FAIL hold_next_latency got %0d want %0d", cyc, e.lat); else pass_cnt++;
    total_cnt++; if (div_result !== e.res || div_tag !== e.tag) $display("FAIL hold_next_result got %h/%h want %h/%h", div_result, div_tag, e.res, e.tag); else pass_cnt++;
    grant();
  endtask

  task automatic test_flush();
    exp_t e;
    int cyc;
    bit ok;
    bit seen;
    send_op(2'b01, 32'd1000, 32'd3, 6'd11, 32'd333, 33);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (div_busy !== 1'b1) $display("FAIL flush_pre_busy got %0b want 1", div_busy); else pass_cnt++;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    total_cnt++; if ({div_ready, div_busy, q_ready} !== 3'b001) $display("FAIL flush_idle got %b want 001", {div_ready, div_busy, q_ready}); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_ready === 1'b1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_ready got %0b want 0", seen); else pass_cnt++;
    send_op(2'b00, 32'd9, 32'd3, 6'd12, 32'd3, 33);
    wait_ready(cyc, ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1 || cyc !== e.lat) $display("FAIL flush_next_latency got %0d want %0d", cyc, e.lat); else pass_cnt++;
    total_cnt++; if (div_result !== e.res || div_tag !== e.tag) $display("FAIL flush_next_result got %h/%h want %h/%h", div_result, div_tag, e.res, e.tag); else pass_cnt++;
    grant();
  endtask

  task automatic test_rst_mid();
    send_op(2'b01, 32'd77, 32'd7, 6'd13, 32'd11, 33);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({div_ready, div_busy, q_ready} !== 3'b000 || div_result !== 32'd0 || div_tag !== 6'd0)
      $display("FAIL rst_mid got rdy/busy/qr=%b res=%h tag=%h want 000 0 0", {div_ready, div_busy, q_ready}, div_result, div_tag);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if ({div_busy, q_ready} !== 2'b01) $display("FAIL rst_release got %b want 01", {div_busy, q_ready}); else pass_cnt++;
    q_valid = 1'b1; flush = 1'b1; q_op = 2'b01; q_rs1 = 32'd8; q_rs2 = 32'd2; q_tag = 6'd14;
    #1;
    total_cnt++; if (q_ready !== 1'b0) $display("FAIL flush_q_ready got %0b want 0", q_ready); else pass_cnt++;
    @(posedge clk);
    #1 q_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    total_cnt++; if ({div_busy, q_ready} !== 2'b01) $display("FAIL flush_beats_valid got %b want 01", {div_busy, q_ready}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    bit ok;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      if (b == 32'hFFFF_FFFF) b = 32'd5;
      send_op(op, a, b, 6'(i + 40), model(op, a, b), 33);
      wait_ready(cyc, ok);
      e = sb.pop_front();
      total_cnt++; if (ok !== 1'b1 || cyc !== e.lat) $display("FAIL b2b%0d_latency got %0d want %0d", i, cyc, e.lat); else pass_cnt++;
      total_cnt++;
      if (div_result !== e.res || div_tag !== e.tag)
        $display("FAIL b2b%0d_result op=%0d a=%h b=%h got %h/%h want %h/%h", i, op, a, b, div_result, div_tag, e.res, e.tag);
      else pass_cnt++;
      grant();
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_hold();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
